// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-back D-cache with 2-word blocks and flush-on-halt.
// Define DCACHE_ATOMIC_EN to build the LL/SC link register.
module dcache_responder #(
  parameter int SETS   = 8,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              halt,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic              datomic,
  input  logic [31:0]       dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  output logic              dhit,
  output logic [WORD_W-1:0] dmemload,
  output logic              flushed,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_store,
  input  logic [WORD_W-1:0] mem_load,
  input  logic              mem_ready
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 32 - IDX - 3;
  localparam logic [IDX-1:0] LAST = IDX'(SETS - 1);

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH_CHK, FLUSH_WB0, FLUSH_WB1, DONE
  } state_t;

  state_t             state_q;
  logic [SETS-1:0]    valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q [SETS];
  logic [WORD_W-1:0]  data_q [SETS][2];
  logic [IDX-1:0]     cnt_q;
  logic               halt_pend_q;

  logic [IDX-1:0]     idx, set_s;
  logic [TAG_W-1:0]   tag;
  logic               w, req, wr, flushing, wb, fetch, beat;
  logic               idle_req, cache_hit, sc_fail, sc_res, do_write;
  logic               unused;

  assign idx       = dmemaddr[IDX+2:3];
  assign tag       = dmemaddr[31:IDX+3];
  assign w         = dmemaddr[2];
  assign req       = dmemREN | dmemWEN;
  assign wr        = dmemWEN;
  assign flushing  = state_q inside {FLUSH_CHK, FLUSH_WB0, FLUSH_WB1};
  assign wb        = state_q inside {WB0, WB1, FLUSH_WB0, FLUSH_WB1};
  assign fetch     = state_q inside {FETCH0, FETCH1};
  assign beat      = state_q inside {WB1, FETCH1, FLUSH_WB1};
  assign set_s     = flushing ? cnt_q : idx;
  assign idle_req  = state_q == IDLE && !halt && req;
  assign cache_hit = valid_q[idx] && tag_q[idx] == tag;
  assign unused    = ^{dmemaddr[1:0], datomic};

`ifdef DCACHE_ATOMIC_EN
  logic        link_v_q;
  logic [29:0] link_a_q;
  logic        link_match;
  assign link_match = link_v_q && link_a_q == dmemaddr[31:2];
  assign sc_fail    = datomic && wr && !link_match;
  assign sc_res     = datomic && wr && link_match;
`else
  assign sc_fail = 1'b0;
  assign sc_res  = 1'b0;
`endif

  // A failing SC completes at once without touching the array or memory
  assign dhit      = idle_req && (cache_hit || sc_fail);
  assign do_write  = dhit && wr && !sc_fail;
  assign dmemload  = !dhit ? '0 : wr ? WORD_W'(sc_res) : data_q[idx][w];
  assign mem_ren   = fetch;
  assign mem_wen   = wb;
  assign mem_addr  = wb ? {tag_q[set_s], set_s, beat, 2'b00} : fetch ? {tag, idx, beat, 2'b00} : '0;
  assign mem_store = wb ? data_q[set_s][beat] : '0;
  assign flushed   = state_q == DONE;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      cnt_q       <= '0;
      halt_pend_q <= 1'b0;
`ifdef DCACHE_ATOMIC_EN
      link_v_q    <= 1'b0;
      link_a_q    <= '0;
`endif
    end else begin
      if (halt && state_q inside {WB0, WB1, FETCH0, FETCH1}) halt_pend_q <= 1'b1;
      unique case (state_q)
        IDLE:
          if (halt) begin
            state_q <= FLUSH_CHK;
            cnt_q   <= '0;
          end else if (do_write) dirty_q[idx] <= 1'b1;
          else if (req && !dhit) state_q <= dirty_q[idx] ? WB0 : FETCH0;
        WB0:    if (mem_ready) state_q <= WB1;
        WB1:    if (mem_ready) state_q <= FETCH0;
        FETCH0: if (mem_ready) state_q <= FETCH1;
        FETCH1:
          if (mem_ready) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            halt_pend_q  <= 1'b0;
            cnt_q        <= '0;
            state_q      <= (halt || halt_pend_q) ? FLUSH_CHK : IDLE;
          end
        FLUSH_CHK:
          if (dirty_q[cnt_q]) state_q <= FLUSH_WB0;
          else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= cnt_q == LAST ? DONE : FLUSH_CHK;
          end
        FLUSH_WB0: if (mem_ready) state_q <= FLUSH_WB1;
        FLUSH_WB1:
          if (mem_ready) begin
            dirty_q[cnt_q] <= 1'b0;
            cnt_q          <= cnt_q + 1'b1;
            state_q        <= cnt_q == LAST ? DONE : FLUSH_CHK;
          end
        default: state_q <= DONE;
      endcase
`ifdef DCACHE_ATOMIC_EN
      if (do_write && link_a_q == dmemaddr[31:2]) link_v_q <= 1'b0;
      else if (dhit && !wr && datomic) begin
        link_v_q <= 1'b1;
        link_a_q <= dmemaddr[31:2];
      end
`endif
    end
  end

  // Tag and data arrays carry no reset; valid gates their use
  always_ff @(posedge CLK) begin
    if (do_write) data_q[idx][w] <= dmemstore;
    if (fetch && mem_ready) data_q[idx][beat] <= mem_load;
    if (state_q == FETCH1 && mem_ready) tag_q[idx] <= tag;
  end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed tests for dcache_responder against a latency-programmable word memory.
module tb_dcache_responder;
  logic        CLK = 1'b0, nRST = 1'b1, halt = 1'b0;
  logic        dmemREN = 1'b0, dmemWEN = 1'b0, datomic = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0;
  logic [31:0] dmemload, mem_addr, mem_store, mem_load;
  logic        dhit, flushed, mem_ren, mem_wen, mem_ready;
  logic [31:0] mem [1024];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic        log_we [$];
  int          lat = 0, wcnt = 0, errors = 0, checks = 0;

  always #5 CLK = ~CLK;

  dcache_responder dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .datomic(datomic), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit),
    .dmemload(dmemload), .flushed(flushed), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_store(mem_store), .mem_load(mem_load), .mem_ready(mem_ready)
  );

  assign mem_ready = (mem_ren || mem_wen) && wcnt >= lat;
  assign mem_load  = mem[mem_addr[11:2]];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5000_0000 + i;
    mem[10'h40] = 32'hAAAA_0000;
    mem[10'h41] = 32'hAAAA_0001;
    forever begin
      @(posedge CLK);
      if (!nRST) wcnt <= 0;
      else if (mem_ready) begin
        wcnt <= 0;
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_wen);
        log_data.push_back(mem_wen ? mem_store : mem_load);
        if (mem_wen) mem[mem_addr[11:2]] = mem_store;
      end else if (mem_ren || mem_wen) wcnt <= wcnt + 1;
    end
  end

  task automatic set_req(input logic ren, input logic wen, input logic atom,
                         input logic [31:0] a, input logic [31:0] d);
    dmemREN = ren; dmemWEN = wen; datomic = atom; dmemaddr = a; dmemstore = d;
  endtask

  task automatic wait_hit(output int cyc);
    cyc = 0;
    while (!dhit && cyc < 40) begin
      @(negedge CLK); #1; cyc++;
    end
  endtask

  task automatic finish_req;
    @(negedge CLK);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset;
    @(negedge CLK);
    nRST = 1'b0; halt = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset;
    #2 nRST = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    #1;
    checks++; if ({dhit, flushed, mem_ren, mem_wen} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got %b want 0000", {dhit, flushed, mem_ren, mem_wen}); end
    checks++; if (dmemload !== 32'h0) begin errors++;
      $display("FAIL reset_load: got %h want 0", dmemload); end
    checks++; if ({mem_addr, mem_store} !== 64'h0) begin errors++;
      $display("FAIL reset_mem: got %h/%h want 0/0", mem_addr, mem_store); end
    @(negedge CLK); @(negedge CLK);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nRST = 1'b1;
    #1;
    checks++; if ({dhit, flushed, mem_ren, mem_wen} !== 4'b0) begin errors++;
      $display("FAIL post_reset_idle: got %b want 0000", {dhit, flushed, mem_ren, mem_wen}); end
  endtask

  task automatic test_cold_read;
    int c, b;
    b = log_addr.size();
    @(negedge CLK);
    set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    #1;
    checks++; if (dhit !== 1'b0) begin errors++;
      $display("FAIL cold_first_cycle: dhit got %b want 0", dhit); end
    wait_hit(c);
    checks++; if (c !== 3) begin errors++;
      $display("FAIL cold_latency: got %0d want 3", c); end
    checks++; if (dmemload !== 32'hAAAA_0000) begin errors++;
      $display("FAIL cold_data: got %h want aaaa0000", dmemload); end
    checks++; if (log_addr.size() !== b + 2 || log_addr[b] !== 32'h100 || log_addr[b+1] !== 32'h104
                  || log_we[b] !== 1'b0 || log_we[b+1] !== 1'b0) begin errors++;
      $display("FAIL cold_fetch_addrs: got n=%0d %h %h want n=%0d 100 104", log_addr.size(),
               log_addr[b], log_addr[b+1], b + 2); end
    @(negedge CLK);
    dmemaddr = 32'h104;
    #1;
    checks++; if (dhit !== 1'b1 || dmemload !== 32'hAAAA_0001) begin errors++;
      $display("FAIL reread_hit: got %b/%h want 1/aaaa0001", dhit, dmemload); end
    finish_req;
  endtask

  task automatic test_dirty_evict;
    int c, b;
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    logic [3:0]  ew;
    ea = '{32'h100, 32'h104, 32'h140, 32'h144};
    ed = '{32'hDEAD_BEEF, 32'hAAAA_0001, 32'h5000_0050, 32'h5000_0051};
    ew = 4'b1100;
    @(negedge CLK);
    set_req(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF);
    #1;
    checks++; if (dhit !== 1'b1) begin errors++;
      $display("FAIL write_hit: dhit got %b want 1", dhit); end
    finish_req;
    #1;
    checks++; if (mem[10'h40] !== 32'hAAAA_0000) begin errors++;
      $display("FAIL write_back_not_through: mem got %h want aaaa0000", mem[10'h40]); end
    b = log_addr.size();
    set_req(1'b1, 1'b0, 1'b0, 32'h140, 32'h0);
    wait_hit(c);
    checks++; if (c !== 5) begin errors++;
      $display("FAIL evict_latency: got %0d want 5", c); end
    checks++; if (dmemload !== 32'h5000_0050) begin errors++;
      $display("FAIL evict_data: got %h want 50000050", dmemload); end
    checks++; if (log_addr.size() !== b + 4) begin errors++;
      $display("FAIL evict_beats: got %0d want 4", log_addr.size() - b); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[b+i] !== ea[i] || log_data[b+i] !== ed[i] || log_we[b+i] !== ew[3-i]) begin errors++;
        $display("FAIL evict_beat%0d: got %h/%h/%b want %h/%h/%b", i, log_addr[b+i], log_data[b+i],
                 log_we[b+i], ea[i], ed[i], ew[3-i]); end
    end
    finish_req;
  endtask

  task automatic test_stretched;
    int c, b;
    logic stable, pact, prdy, pr, pw;
    logic [31:0] pa, ps;
    logic [31:0] ea [4];
    ea = '{32'h140, 32'h144, 32'h180, 32'h184};
    @(negedge CLK);
    set_req(1'b0, 1'b1, 1'b0, 32'h140, 32'h1234_5678);
    finish_req;
    lat = 3;
    b = log_addr.size();
    set_req(1'b1, 1'b0, 1'b0, 32'h180, 32'h0);
    #1;
    c = 0; stable = 1'b1;
    pa = mem_addr; ps = mem_store; pr = mem_ren; pw = mem_wen;
    pact = mem_ren | mem_wen; prdy = mem_ready;
    while (!dhit && c < 60) begin
      @(negedge CLK); #1; c++;
      if (pact && !prdy && {mem_addr, mem_store, mem_ren, mem_wen} !== {pa, ps, pr, pw}) stable = 1'b0;
      pa = mem_addr; ps = mem_store; pr = mem_ren; pw = mem_wen;
      pact = mem_ren | mem_wen; prdy = mem_ready;
    end
    checks++; if (stable !== 1'b1) begin errors++;
      $display("FAIL stretch_stable: got %b want 1", stable); end
    checks++; if (c !== 17) begin errors++;
      $display("FAIL stretch_latency: got %0d want 17", c); end
    checks++; if (dmemload !== 32'h5000_0060) begin errors++;
      $display("FAIL stretch_data: got %h want 50000060", dmemload); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[b+i] !== ea[i] || log_we[b+i] !== (i < 2)) begin errors++;
        $display("FAIL stretch_beat%0d: got %h/%b want %h/%b", i, log_addr[b+i], log_we[b+i], ea[i], i < 2); end
    end
    checks++; if (log_data[b] !== 32'h1234_5678) begin errors++;
      $display("FAIL stretch_wb_data: got %h want 12345678", log_data[b]); end
    finish_req;
    lat = 0;
  endtask

  task automatic test_flush;
    int c, b;
    logic bad;
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    ea = '{32'h180, 32'h184, 32'h028, 32'h02C};
    ed = '{32'hCAFE_0000, 32'h5000_0061, 32'hBEEF_0005, 32'h5000_000B};
    @(negedge CLK);
    set_req(1'b0, 1'b1, 1'b0, 32'h180, 32'hCAFE_0000);
    finish_req;
    set_req(1'b0, 1'b1, 1'b0, 32'h028, 32'hBEEF_0005);
    #1;
    wait_hit(c);
    checks++; if (c !== 3) begin errors++;
      $display("FAIL write_miss_latency: got %0d want 3", c); end
    finish_req;
    b = log_addr.size();
    halt = 1'b1;
    #1;
    c = 0;
    while (!flushed && c < 60) begin
      @(negedge CLK); #1; c++;
    end
    checks++; if (c !== 13) begin errors++;
      $display("FAIL flush_duration: got %0d want 13", c); end
    checks++; if (log_addr.size() !== b + 4) begin errors++;
      $display("FAIL flush_beats: got %0d want 4", log_addr.size() - b); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[b+i] !== ea[i] || log_data[b+i] !== ed[i] || log_we[b+i] !== 1'b1) begin errors++;
        $display("FAIL flush_beat%0d: got %h/%h/%b want %h/%h/1", i, log_addr[b+i], log_data[b+i],
                 log_we[b+i], ea[i], ed[i]); end
    end
    checks++; if (mem[10'h60] !== 32'hCAFE_0000 || mem[10'h0A] !== 32'hBEEF_0005) begin errors++;
      $display("FAIL flush_mem: got %h/%h want cafe0000/beef0005", mem[10'h60], mem[10'h0A]); end
    bad = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 32'h180, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin halt = 1'b0; dmemaddr = 32'h100; end
      #1;
      if (dhit || !flushed || mem_ren || mem_wen) bad = 1'b1;
      @(negedge CLK);
    end
    checks++; if (bad !== 1'b0) begin errors++;
      $display("FAIL done_sticky: got bad=%b want 0", bad); end
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_atomic;
    int c, b;
    do_reset;
`ifdef DCACHE_ATOMIC_EN
    set_req(1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
    #1;
    wait_hit(c);
    checks++; if (c !== 3 || dmemload !== 32'h5000_0080) begin errors++;
      $display("FAIL ll_read: got %0d/%h want 3/50000080", c, dmemload); end
    finish_req;
    set_req(1'b0, 1'b1, 1'b1, 32'h200, 32'h1111_1111);
    #1;
    checks++; if (dhit !== 1'b1 || dmemload !== 32'h1) begin errors++;
      $display("FAIL sc_success: got %b/%h want 1/1", dhit, dmemload); end
    finish_req;
    set_req(1'b1, 1'b0, 1'b0, 32'h240, 32'h0);
    #1;
    wait_hit(c);
    checks++; if (c !== 5 || mem[10'h80] !== 32'h1111_1111) begin errors++;
      $display("FAIL sc_mem_update: got %0d/%h want 5/11111111", c, mem[10'h80]); end
    finish_req;
    set_req(1'b1, 1'b0, 1'b1, 32'h240, 32'h0);
    finish_req;
    set_req(1'b0, 1'b1, 1'b0, 32'h240, 32'h2222_2222);
    finish_req;
    b = log_addr.size();
    set_req(1'b0, 1'b1, 1'b1, 32'h240, 32'h3333_3333);
    #1;
    checks++; if (dhit !== 1'b1 || dmemload !== 32'h0) begin errors++;
      $display("FAIL sc_broken_link: got %b/%h want 1/0", dhit, dmemload); end
    finish_req;
    set_req(1'b1, 1'b0, 1'b0, 32'h240, 32'h0);
    #1;
    checks++; if (dhit !== 1'b1 || dmemload !== 32'h2222_2222) begin errors++;
      $display("FAIL sc_no_write: got %b/%h want 1/22222222", dhit, dmemload); end
    finish_req;
    set_req(1'b0, 1'b1, 1'b1, 32'h300, 32'h4444_4444);
    #1;
    checks++; if (dhit !== 1'b1 || dmemload !== 32'h0) begin errors++;
      $display("FAIL sc_no_link_miss: got %b/%h want 1/0", dhit, dmemload); end
    finish_req;
    @(negedge CLK); @(negedge CLK);
    checks++; if (log_addr.size() !== b) begin errors++;
      $display("FAIL sc_fail_no_traffic: got %0d beats want 0", log_addr.size() - b); end
`else
    set_req(1'b0, 1'b1, 1'b1, 32'h200, 32'h1111_1111);
    #1;
    wait_hit(c);
    checks++; if (c !== 3 || dmemload !== 32'h0) begin errors++;
      $display("FAIL sc_plain_write: got %0d/%h want 3/0", c, dmemload); end
    finish_req;
    set_req(1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    #1;
    checks++; if (dhit !== 1'b1 || dmemload !== 32'h1111_1111) begin errors++;
      $display("FAIL sc_plain_readback: got %b/%h want 1/11111111", dhit, dmemload); end
    finish_req;
`endif
  endtask

  task automatic test_reset_mid_fill;
    int c, b;
    do_reset;
    lat = 2;
    b = log_addr.size();
    set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    #1;
    c = 0;
    while (log_addr.size() < b + 1 && c < 40) begin
      @(negedge CLK); #1; c++;
    end
    checks++; if (mem_ren !== 1'b1 || mem_addr !== 32'h104) begin errors++;
      $display("FAIL fetch1_reached: got %b/%h want 1/104", mem_ren, mem_addr); end
    nRST = 1'b0;
    #1;
    checks++; if ({dhit, flushed, mem_ren, mem_wen} !== 4'b0 || {mem_addr, mem_store, dmemload} !== 96'h0) begin errors++;
      $display("FAIL midfill_reset: got %b %h %h %h want 0000 0 0 0", {dhit, flushed, mem_ren, mem_wen},
               mem_addr, mem_store, dmemload); end
    @(negedge CLK);
    nRST = 1'b1;
    lat = 0;
    b = log_addr.size();
    #1;
    wait_hit(c);
    checks++; if (c !== 3 || dmemload !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL refill_after_reset: got %0d/%h want 3/deadbeef", c, dmemload); end
    checks++; if (log_addr.size() !== b + 2 || log_addr[b] !== 32'h100 || log_addr[b+1] !== 32'h104) begin errors++;
      $display("FAIL refill_addrs: got n=%0d %h %h want 2 100 104", log_addr.size() - b, log_addr[b], log_addr[b+1]); end
    finish_req;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_cold_read;
    test_dirty_evict;
    test_stretched;
    test_flush;
    test_atomic;
    test_reset_mid_fill;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
